// File: rtl/mac_multi_if.sv
// mac_multi_if: bus bundle between the openMSP430 core side and the
// multi-module memory access controller. The master drives core bus
// activity and configuration. The slave (mac_multi) returns the reset
// request and the violation status.
interface mac_multi_if #(
   parameter int NUM_MOD = 4
);
   localparam int MOD_W = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1;

   // core bus activity
   logic [15:0]      pc;
   logic [15:0]      data_addr;
   logic             data_en;
   logic [15:0]      code_addr;
   logic             code_en;
   logic             code_wr;

   // configuration
   logic             cfg_wr;
   logic [MOD_W-1:0] cfg_idx;
   logic [2:0]       cfg_sel;
   logic [15:0]      cfg_data;
   logic             cfg_lock;
   logic             viol_clr;

   // responses
   logic             reset;
   logic             locked;
   logic             viol_valid;
   logic [2:0]       viol_cause;
   logic [MOD_W-1:0] viol_mod;
   logic [15:0]      viol_cnt;

   modport master (
      output pc, data_addr, data_en, code_addr, code_en, code_wr,
      output cfg_wr, cfg_idx, cfg_sel, cfg_data, cfg_lock, viol_clr,
      input  reset, locked, viol_valid, viol_cause, viol_mod, viol_cnt
   );

   modport slave (
      input  pc, data_addr, data_en, code_addr, code_en, code_wr,
      input  cfg_wr, cfg_idx, cfg_sel, cfg_data, cfg_lock, viol_clr,
      output reset, locked, viol_valid, viol_cause, viol_mod, viol_cnt
   );
endinterface

// File: rtl/mac_multi.sv
// mac_multi: memory access controller that isolates NUM_MOD protected
// modules. Each module has an inclusive text range and an inclusive data
// range. Core bus activity is checked every cycle. A violation starts a
// registered reset pulse of RST_PULSE cycles and records its cause and
// module index in sticky status.
// Optional feature: define MAC_VIOL_COUNT_EN to get a saturating 16-bit
// count of accepted violations on viol_cnt. When it is undefined,
// viol_cnt is tied to zero.
module mac_multi #(
   parameter int NUM_MOD   = 4,
   parameter int RST_PULSE = 4
) (
   input  logic       clk,
   input  logic       rst,
   mac_multi_if.slave bus
);
   localparam int MOD_W = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1;

   localparam logic [2:0] CAUSE_NONE  = 3'd0;
   localparam logic [2:0] CAUSE_ENTRY = 3'd1;
   localparam logic [2:0] CAUSE_DATA  = 3'd2;
   localparam logic [2:0] CAUSE_TEXT  = 3'd3;
   localparam logic [2:0] CAUSE_WRITE = 3'd4;

   typedef enum logic {MON, PULSE} state_t;

   // per-module configuration
   logic [15:0]        ts_q [NUM_MOD];
   logic [15:0]        ts_d [NUM_MOD];
   logic [15:0]        te_q [NUM_MOD];
   logic [15:0]        te_d [NUM_MOD];
   logic [15:0]        ds_q [NUM_MOD];
   logic [15:0]        ds_d [NUM_MOD];
   logic [15:0]        de_q [NUM_MOD];
   logic [15:0]        de_d [NUM_MOD];
   logic [NUM_MOD-1:0] en_q, en_d;
   logic               locked_q, locked_d;

   // previous fetch tracking for the entry-point check
   logic [15:0]        prev_pc_q, prev_pc_d;
   logic               prev_valid_q, prev_valid_d;

   // reset pulse sequencer
   state_t             state_q, state_d;
   logic [3:0]         pcnt_q, pcnt_d;
   logic               reset_q, reset_d;

   // sticky violation status
   logic               viol_valid_q, viol_valid_d;
   logic [2:0]         viol_cause_q, viol_cause_d;
   logic [MOD_W-1:0]   viol_mod_q, viol_mod_d;

   // combinational violation summary
   logic               hit;
   logic [2:0]         hit_cause;
   logic [MOD_W-1:0]   hit_mod;
   logic [2:0]         mod_c;
   logic               accept;

   // Inclusive range test. A start above the stop gives an empty range.
   function automatic logic in_rng(input logic [15:0] lo, input logic [15:0] hi,
                                   input logic [15:0] a);
      return (lo <= a) && (a <= hi);
   endfunction

   // Highest-priority violation of one module, or CAUSE_NONE.
   function automatic logic [2:0] mod_cause(
      input logic [15:0] ts, input logic [15:0] te,
      input logic [15:0] ds, input logic [15:0] de,
      input logic [15:0] pc, input logic [15:0] prev_pc, input logic prev_valid,
      input logic        data_en, input logic [15:0] data_addr,
      input logic        code_en, input logic code_wr, input logic [15:0] code_addr);
      logic pc_in, prev_in, code_in, data_in;
      pc_in   = in_rng(ts, te, pc);
      prev_in = in_rng(ts, te, prev_pc);
      code_in = in_rng(ts, te, code_addr);
      data_in = in_rng(ds, de, data_addr);
      if (pc_in && (pc != ts) && !(prev_valid && prev_in))
         return CAUSE_ENTRY;
      else if (data_en && data_in && !pc_in)
         return CAUSE_DATA;
      else if (code_en && code_in && !pc_in)
         return CAUSE_TEXT;
      else if (code_en && code_wr && code_in && pc_in)
         return CAUSE_WRITE;
      return CAUSE_NONE;
   endfunction

   // Configuration writes and lock. A write and a lock in the same cycle
   // both take effect because the write is gated by the current lock state.
   always_comb begin
      // NOTE: every signal gets its default first, so no path can leave one
      // unassigned. Missing defaults are how latches get inferred.
      ts_d     = ts_q;
      te_d     = te_q;
      ds_d     = ds_q;
      de_d     = de_q;
      en_d     = en_q;
      locked_d = locked_q | bus.cfg_lock;
      if (bus.cfg_wr && !locked_q && (bus.cfg_sel <= 3'd4)) begin
         for (int i = 0; i < NUM_MOD; i++) begin
            if (MOD_W'(i) == bus.cfg_idx) begin
               case (bus.cfg_sel)
                  3'd0:    ts_d[i] = bus.cfg_data;
                  3'd1:    te_d[i] = bus.cfg_data;
                  3'd2:    ds_d[i] = bus.cfg_data;
                  3'd3:    de_d[i] = bus.cfg_data;
                  3'd4:    en_d[i] = bus.cfg_data[0];
                  default: ;
               endcase
            end
         end
      end
   end

   // Scan enabled modules from the highest index down, so the lowest
   // violating index is the one that remains.
   always_comb begin
      hit       = 1'b0;
      hit_cause = CAUSE_NONE;
      hit_mod   = '0;
      mod_c     = CAUSE_NONE;
      for (int i = NUM_MOD - 1; i >= 0; i--) begin
         mod_c = mod_cause(ts_q[i], te_q[i], ds_q[i], de_q[i],
                           bus.pc, prev_pc_q, prev_valid_q,
                           bus.data_en, bus.data_addr,
                           bus.code_en, bus.code_wr, bus.code_addr);
         if (en_q[i] && (mod_c != CAUSE_NONE)) begin
            hit       = 1'b1;
            hit_cause = mod_c;
            hit_mod   = MOD_W'(i);
         end
      end
   end

   // Pulse FSM, previous-PC tracking and sticky status update.
   always_comb begin
      state_d      = state_q;
      pcnt_d       = pcnt_q;
      reset_d      = reset_q;
      prev_pc_d    = bus.pc;
      prev_valid_d = 1'b0;
      viol_valid_d = viol_valid_q;
      viol_cause_d = viol_cause_q;
      viol_mod_d   = viol_mod_q;
      accept       = 1'b0;
      case (state_q)
         MON: begin
            prev_valid_d = 1'b1;
            if (hit) begin
               accept  = 1'b1;
               state_d = PULSE;
               reset_d = 1'b1;
               pcnt_d  = 4'(RST_PULSE - 1);
            end
         end
         PULSE: begin
            // Violations seen here are ignored; the core is being reset.
            if (pcnt_q == 4'd0) begin
               state_d = MON;
               reset_d = 1'b0;
            end else begin
               pcnt_d = pcnt_q - 4'd1;
            end
         end
         default: state_d = MON;
      endcase
      if (bus.viol_clr) begin
         viol_valid_d = 1'b0;
         viol_cause_d = CAUSE_NONE;
         viol_mod_d   = '0;
      end
      // A new violation is latched over a clear in the same cycle, but
      // never over an earlier recorded one.
      if (accept && (!viol_valid_q || bus.viol_clr)) begin
         viol_valid_d = 1'b1;
         viol_cause_d = hit_cause;
         viol_mod_d   = hit_mod;
      end
   end

   // State registers. Configuration is part of the security state and must
   // come up empty and disabled, so the region registers are reset too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the region arrays are reset on purpose. A protected region
         // with an unknown power-up value would make the checks meaningless.
         for (int i = 0; i < NUM_MOD; i++) begin
            ts_q[i] <= '0;
            te_q[i] <= '0;
            ds_q[i] <= '0;
            de_q[i] <= '0;
         end
         en_q         <= '0;
         locked_q     <= 1'b0;
         prev_pc_q    <= '0;
         prev_valid_q <= 1'b0;
         state_q      <= MON;
         pcnt_q       <= '0;
         reset_q      <= 1'b0;
         viol_valid_q <= 1'b0;
         viol_cause_q <= CAUSE_NONE;
         viol_mod_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the old
         // value of the others, which is what keeps this block order-independent.
         ts_q         <= ts_d;
         te_q         <= te_d;
         ds_q         <= ds_d;
         de_q         <= de_d;
         en_q         <= en_d;
         locked_q     <= locked_d;
         prev_pc_q    <= prev_pc_d;
         prev_valid_q <= prev_valid_d;
         state_q      <= state_d;
         pcnt_q       <= pcnt_d;
         reset_q      <= reset_d;
         viol_valid_q <= viol_valid_d;
         viol_cause_q <= viol_cause_d;
         viol_mod_q   <= viol_mod_d;
      end
   end

`ifdef MAC_VIOL_COUNT_EN
   logic [15:0] viol_cnt_q, viol_cnt_d;

   // Saturating count of accepted violations. Only rst clears it.
   always_comb begin
      viol_cnt_d = viol_cnt_q;
      if (accept && (viol_cnt_q != 16'hFFFF))
         viol_cnt_d = viol_cnt_q + 16'd1;
   end

   // Violation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) viol_cnt_q <= '0;
      else     viol_cnt_q <= viol_cnt_d;
   end

   assign bus.viol_cnt = viol_cnt_q;
`else
   assign bus.viol_cnt = 16'h0000;
`endif

   assign bus.reset      = reset_q;
   assign bus.locked     = locked_q;
   assign bus.viol_valid = viol_valid_q;
   assign bus.viol_cause = viol_cause_q;
   assign bus.viol_mod   = viol_mod_q;

endmodule

// File: tb/tb_mac_multi.sv
// tb_mac_multi: directed testbench for mac_multi. The stimulus pushes the
// expected status and pulse length of each reset pulse into a scoreboard.
// A monitor pops one entry per observed pulse and compares it against the
// DUT. Static status such as lock, sticky status and the count is checked
// inline.
module tb_mac_multi;
   localparam int NUM_MOD   = 4;
   localparam int RST_PULSE = 4;

   typedef struct {
      logic [2:0] cause;
      logic [1:0] mod;
      int         len;
   } exp_t;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   mac_multi_if #(.NUM_MOD(NUM_MOD)) bus ();

   mac_multi #(.NUM_MOD(NUM_MOD), .RST_PULSE(RST_PULSE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      bus.pc        = 16'h8000;
      bus.data_addr = 16'h0000;
      bus.data_en   = 1'b0;
      bus.code_addr = 16'h0000;
      bus.code_en   = 1'b0;
      bus.code_wr   = 1'b0;
      bus.cfg_wr    = 1'b0;
      bus.cfg_idx   = '0;
      bus.cfg_sel   = '0;
      bus.cfg_data  = '0;
      bus.cfg_lock  = 1'b0;
      bus.viol_clr  = 1'b0;
   endtask

   task automatic cfg(input logic [1:0] idx, input logic [2:0] sel,
                      input logic [15:0] data, input logic lock);
      bus.cfg_wr   = 1'b1;
      bus.cfg_idx  = idx;
      bus.cfg_sel  = sel;
      bus.cfg_data = data;
      bus.cfg_lock = lock;
      step(1);
      bus.cfg_wr   = 1'b0;
      bus.cfg_lock = 1'b0;
   endtask

   task automatic cfg_mod0();
      cfg(2'd0, 3'd0, 16'hA000, 1'b0);
      cfg(2'd0, 3'd1, 16'hA400, 1'b0);
      cfg(2'd0, 3'd2, 16'h0500, 1'b0);
      cfg(2'd0, 3'd3, 16'h0C00, 1'b0);
      cfg(2'd0, 3'd4, 16'h0001, 1'b0);
   endtask

   // Data access from outside any text range, held for one cycle.
   task automatic viol_data(input logic [15:0] addr);
      bus.pc        = 16'h8000;
      bus.data_en   = 1'b1;
      bus.data_addr = addr;
      step(1);
      idle();
   endtask

   task automatic clear_status();
      bus.viol_clr = 1'b1;
      step(1);
      bus.viol_clr = 1'b0;
   endtask

   task automatic push(input logic [2:0] cause, input logic [1:0] mod, input int len);
      exp_t e;
      e.cause = cause;
      e.mod   = mod;
      e.len   = len;
      sb.push_back(e);
   endtask

   // Monitor: samples on the falling edge. It pops one scoreboard entry at
   // the start of each pulse and checks the pulse length when it ends.
   initial begin
      bit   in_p;
      bit   have_e;
      int   len;
      exp_t e;
      in_p   = 1'b0;
      have_e = 1'b0;
      len    = 0;
      forever begin
         @(negedge clk);
         if (bus.reset && !in_p) begin
            in_p = 1'b1;
            len  = 1;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               have_e = 1'b0;
               $display("FAIL unexpected_pulse: got reset=1, expected reset=0");
            end else begin
               e      = sb.pop_front();
               have_e = 1'b1;
               check("pulse_viol_valid", 32'(bus.viol_valid), 32'd1);
               check("pulse_viol_cause", 32'(bus.viol_cause), 32'(e.cause));
               check("pulse_viol_mod",   32'(bus.viol_mod),   32'(e.mod));
            end
         end else if (bus.reset && in_p) begin
            len++;
            if (len == 40) begin
               checks++;
               errors++;
               $display("FAIL pulse_stuck: got length %0d, expected %0d", len, RST_PULSE);
            end
         end else if (!bus.reset && in_p) begin
            in_p = 1'b0;
            if (have_e) check("pulse_len", 32'(len), 32'(e.len));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: got no finish, expected finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      idle();
      step(3);
      check("rst_reset",      32'(bus.reset),      32'd0);
      check("rst_locked",     32'(bus.locked),     32'd0);
      check("rst_viol_valid", 32'(bus.viol_valid), 32'd0);
      check("rst_viol_cause", 32'(bus.viol_cause), 32'd0);
      check("rst_viol_mod",   32'(bus.viol_mod),   32'd0);
      check("rst_viol_cnt",   32'(bus.viol_cnt),   32'd0);
      rst = 1'b0;
      step(2);

      // configuration: module 0, module 1 (text D000-DFFF, empty data),
      // module 2 (text B000-B100, data 0800-0900). The last write carries the lock.
      cfg_mod0();
      cfg(2'd1, 3'd0, 16'hD000, 1'b0);
      cfg(2'd1, 3'd1, 16'hDFFF, 1'b0);
      cfg(2'd1, 3'd2, 16'hFFFF, 1'b0);
      cfg(2'd1, 3'd4, 16'h0001, 1'b0);
      cfg(2'd2, 3'd0, 16'hB000, 1'b0);
      cfg(2'd2, 3'd1, 16'hB100, 1'b0);
      cfg(2'd2, 3'd2, 16'h0800, 1'b0);
      cfg(2'd2, 3'd3, 16'h0900, 1'b0);
      check("pre_lock_locked", 32'(bus.locked), 32'd0);
      cfg(2'd2, 3'd4, 16'h0001, 1'b1);
      check("lock_locked", 32'(bus.locked), 32'd1);
      step(2);

      // 1: data access to module 0 data from outside its text
      push(3'd2, 2'd0, RST_PULSE);
      viol_data(16'h0600);
      step(8);
      check("t1_sticky_valid", 32'(bus.viol_valid), 32'd1);
      check("t1_sticky_cause", 32'(bus.viol_cause), 32'd2);
      clear_status();
      check("t1_clr_valid", 32'(bus.viol_valid), 32'd0);

      // 2: legal entry at A000, then an illegal entry at A010
      bus.pc = 16'hA000; step(1);
      bus.pc = 16'hA002; step(1);
      bus.pc = 16'hA004; step(1);
      bus.pc = 16'h8000; step(1);
      push(3'd1, 2'd0, RST_PULSE);
      bus.pc = 16'hA010; step(1);
      idle();
      step(8);
      clear_status();

      // 3: code write inside text from inside text, then a code read
      bus.pc = 16'hA000; step(1);
      bus.pc = 16'hA100; step(1);
      push(3'd4, 2'd0, RST_PULSE);
      bus.code_en = 1'b1; bus.code_wr = 1'b1; bus.code_addr = 16'hA200;
      step(1);
      idle();
      step(8);
      clear_status();
      bus.pc = 16'hA000; step(1);
      bus.pc = 16'hA100; step(1);
      bus.code_en = 1'b1; bus.code_wr = 1'b0; bus.code_addr = 16'hA200;
      step(1);
      idle();
      step(8);
      check("t3_read_no_viol", 32'(bus.viol_valid), 32'd0);

      // 4: modules 0 and 2 hit together; module 0 wins. A second violation
      //    during the pulse is ignored.
      push(3'd2, 2'd0, RST_PULSE);
      viol_data(16'h0850);
      bus.code_en = 1'b1; bus.code_addr = 16'hB010;
      step(1);
      idle();
      step(8);
      check("t4_status_cause", 32'(bus.viol_cause), 32'd2);
      check("t4_status_mod",   32'(bus.viol_mod),   32'd0);
      // clear together with a new text read of module 2: the new one is latched
      push(3'd3, 2'd2, RST_PULSE);
      bus.viol_clr = 1'b1; bus.code_en = 1'b1; bus.code_addr = 16'hB010;
      step(1);
      idle();
      step(8);
      check("t4_setwins_cause", 32'(bus.viol_cause), 32'd3);
      clear_status();
      check("t4_clr_valid", 32'(bus.viol_valid), 32'd0);
      check("t4_clr_cause", 32'(bus.viol_cause), 32'd0);
      check("t4_clr_mod",   32'(bus.viol_mod),   32'd0);
`ifdef MAC_VIOL_COUNT_EN
      check("cnt_five", 32'(bus.viol_cnt), 32'd5);
`else
      check("cnt_tied", 32'(bus.viol_cnt), 32'd0);
`endif

      // 5: a write after lock is ignored, so C002 stays outside module 1 text
      cfg(2'd1, 3'd0, 16'hC000, 1'b0);
      bus.pc = 16'hC002; step(1);
      idle();
      step(6);
      check("t5_still_locked", 32'(bus.locked), 32'd1);
      check("t5_no_viol",      32'(bus.viol_valid), 32'd0);
      // rst in the second pulse cycle ends the pulse at once
      push(3'd2, 2'd0, 1);
      viol_data(16'h0600);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("t5_rst_reset",  32'(bus.reset),      32'd0);
      check("t5_rst_locked", 32'(bus.locked),     32'd0);
      check("t5_rst_valid",  32'(bus.viol_valid), 32'd0);
      check("t5_rst_cnt",    32'(bus.viol_cnt),   32'd0);
      step(2);
      rst = 1'b0;
      step(2);

      // 6: configuration is gone after rst; no violation on module 0 data
      viol_data(16'h0600);
      step(6);
      check("t6_cleared_cfg", 32'(bus.viol_valid), 32'd0);
      // reconfigure, then three separate violations without clearing
      cfg_mod0();
      push(3'd2, 2'd0, RST_PULSE);
      viol_data(16'h0600);
      step(8);
      push(3'd2, 2'd0, RST_PULSE);
      viol_data(16'h0C00);
      step(8);
      push(3'd2, 2'd0, RST_PULSE);
      viol_data(16'h0500);
      step(8);
`ifdef MAC_VIOL_COUNT_EN
      check("t6_cnt_three", 32'(bus.viol_cnt), 32'd3);
      force dut.viol_cnt_q = 16'hFFFE;
      step(1);
      release dut.viol_cnt_q;
      push(3'd2, 2'd0, RST_PULSE);
      viol_data(16'h0600);
      step(8);
      check("t6_cnt_ffff", 32'(bus.viol_cnt), 32'hFFFF);
      push(3'd2, 2'd0, RST_PULSE);
      viol_data(16'h0600);
      step(8);
      check("t6_cnt_sat", 32'(bus.viol_cnt), 32'hFFFF);
`else
      check("t6_cnt_tied", 32'(bus.viol_cnt), 32'd0);
`endif

      step(4);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
